// File: rtl/tpu_io_ctrl.sv
// -----------------------------------------------------------------------------
// tpu_io_ctrl
//
// Host-side I/O sequencer for the TPU core. It moves one matrix transfer
// through four phases:
//   IDLE -> LOAD : the first host row arrives. The GEMM dimensions are
//                  latched and the row is written to buffer address 0.
//   LOAD -> RUN  : row ROWS-1 has been written. start pulses for one cycle,
//                  in the same cycle as that final write.
//   RUN  -> READ : the core pulses done.
//   READ -> IDLE : ROWS result rows have been streamed out on gbuff_out.
//
// Ports
//   clk, rst             clock (rising edge); asynchronous active-high reset
//   in_valid             host row strobe
//   gbuff_a, gbuff_b     host rows of matrix A and matrix B
//   m, n, k              GEMM dimensions, sampled on the first row only
//   wr_en                A/B buffer write strobe, one cycle after in_valid
//   wr_addr              A/B buffer write address (row index)
//   wr_data_a/b          A/B buffer write data
//   start                one-cycle pulse that starts the core
//   m_o, n_o, k_o        latched GEMM dimensions
//   done                 one-cycle completion pulse from the core
//   rd_en, rd_addr       output-buffer read strobe and address
//   rd_data              output-buffer data, valid one cycle after rd_en
//   out_valid, gbuff_out result row stream; gbuff_out is zero when idle
//   busy                 high in every state except IDLE
//   proto_err            sticky flag for host/core protocol violations
// -----------------------------------------------------------------------------
module tpu_io_ctrl #(
  parameter int WORD_SIZE = 256,
  parameter int ROWS      = 32,
  localparam int ADDR_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] gbuff_a,
  input  logic [WORD_SIZE-1:0] gbuff_b,
  input  logic [4:0]           m,
  input  logic [4:0]           n,
  input  logic [4:0]           k,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [WORD_SIZE-1:0] wr_data_a,
  output logic [WORD_SIZE-1:0] wr_data_b,
  output logic                 start,
  output logic [4:0]           m_o,
  output logic [4:0]           n_o,
  output logic [4:0]           k_o,
  input  logic                 done,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [WORD_SIZE-1:0] rd_data,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] gbuff_out,
  output logic                 busy,
  output logic                 proto_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_READ = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] row_cnt;     // index of the next host row to accept
  logic              rd_valid_q;  // rd_data carries a requested row this cycle

  logic accept;     // host row taken this cycle
  logic last_row;   // the row being offered is the final row of the transfer
  logic done_ok;    // a completion pulse that actually counts
  logic read_last;  // final result row is on the output this cycle
  logic err_event;  // protocol violation seen this cycle

  // Rows are accepted only while a transfer is being collected. The row
  // counter is zero in IDLE, so the first row always lands at address 0.
  assign accept    = in_valid && (state == S_IDLE || state == S_LOAD);
  assign last_row  = (row_cnt == LAST_ROW);
  // start is high during the first RUN cycle; a done in that same cycle is
  // treated as stale and dropped.
  assign done_ok   = done && (state == S_RUN) && !start;
  // Once reads have stopped, the first out_valid cycle with no data still in
  // flight behind it is the last result row.
  assign read_last = (state == S_READ) && out_valid && !rd_valid_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // values from before the edge, regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept)             state_nxt = last_row ? S_RUN : S_LOAD;
      S_LOAD: if (accept && last_row) state_nxt = S_RUN;
      S_RUN:  if (done_ok)            state_nxt = S_READ;
      S_READ: if (read_last)          state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    err_event = 1'b0;
    unique case (state)
      S_IDLE: err_event = done;
      S_LOAD: begin
        busy      = 1'b1;
        err_event = done;
      end
      S_RUN: begin
        busy      = 1'b1;
        err_event = in_valid;
      end
      S_READ: begin
        busy      = 1'b1;
        err_event = in_valid || done;
      end
      default: begin
        busy      = 1'b0;
        err_event = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: write port, read sequencer, result stream, error flag
  // ---------------------------------------------------------------------------
  // NOTE: the wide data registers are reset along with the control bits so
  // every output reads zero while rst is high, not just the strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data_a  <= '0;
      wr_data_b  <= '0;
      start      <= 1'b0;
      m_o        <= '0;
      n_o        <= '0;
      k_o        <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      rd_valid_q <= 1'b0;
      out_valid  <= 1'b0;
      gbuff_out  <= '0;
      proto_err  <= 1'b0;
    end else begin
      // Write port: a registered copy of each accepted host row.
      wr_en <= accept;
      start <= accept && last_row;
      if (accept) begin
        wr_addr   <= row_cnt;
        wr_data_a <= gbuff_a;
        wr_data_b <= gbuff_b;
        // The counter returns to zero only at the end of a transfer.
        row_cnt   <= last_row ? '0 : row_cnt + 1'b1;
      end

      // Dimensions are taken from the first row of each transfer only.
      if (accept && state == S_IDLE) begin
        m_o <= m;
        n_o <= n;
        k_o <= k;
      end

      // Read sequencer: ROWS back-to-back reads beginning at address 0.
      if (done_ok) begin
        rd_en   <= 1'b1;
        rd_addr <= '0;
      end else if (rd_en) begin
        if (rd_addr == LAST_ROW) begin
          rd_en   <= 1'b0;
          rd_addr <= '0;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end

      // Two-stage result path: rd_data arrives one cycle after rd_en and is
      // then registered, so out_valid trails rd_en by two cycles.
      rd_valid_q <= rd_en;
      out_valid  <= rd_valid_q;
      gbuff_out  <= rd_valid_q ? rd_data : '0;

      if (err_event) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tpu_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tpu_io_ctrl
//
// Self-checking bench for tpu_io_ctrl. Each transfer is described as a list
// of host rows (random or patterned), an optional idle gap, a core latency
// and optional protocol noise. The expected behaviour of every cycle is
// derived from that description: a row driven in cycle c appears as a write
// in cycle c+1; start coincides with the last write; done in cycle D gives
// reads in D+1..D+ROWS and result rows in D+3..D+ROWS+2. A small output
// memory returns {bytes of (addr ^ salt)} one cycle after each read.
// -----------------------------------------------------------------------------
module tb_tpu_io_ctrl;

  localparam int W  = 256;
  localparam int R  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  gbuff_a, gbuff_b;
  logic [4:0]    m, n, k;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data_a, wr_data_b;
  logic          start;
  logic [4:0]    m_o, n_o, k_o;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          out_valid;
  logic [W-1:0]  gbuff_out;
  logic          busy;
  logic          proto_err;

  tpu_io_ctrl #(.WORD_SIZE(W), .ROWS(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .gbuff_a   (gbuff_a),
    .gbuff_b   (gbuff_b),
    .m         (m),
    .n         (n),
    .k         (k),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data_a (wr_data_a),
    .wr_data_b (wr_data_b),
    .start     (start),
    .m_o       (m_o),
    .n_o       (n_o),
    .k_o       (k_o),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .gbuff_out (gbuff_out),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] rep(input logic [7:0] b);
    logic [W-1:0] v;
    for (int i = 0; i < W / 8; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Output-buffer model: data one cycle after a read, junk otherwise.
  logic [7:0] salt = 8'd0;
  always @(posedge clk) rd_data <= rd_en ? rep({3'b000, rd_addr} ^ salt) : rnd_word();

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected sticky error flag; a violation driven in one cycle shows up on
  // proto_err in the next.
  logic exp_perr  = 1'b0;
  logic perr_pend = 1'b0;

  task automatic tick();
    @(negedge clk);
    exp_perr  = exp_perr | perr_pend;
    perr_pend = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".wr_en"},     W'(wr_en),     W'(0));
    check({tag, ".start"},     W'(start),     W'(0));
    check({tag, ".rd_en"},     W'(rd_en),     W'(0));
    check({tag, ".out_valid"}, W'(out_valid), W'(0));
    check({tag, ".gbuff_out"}, gbuff_out,     W'(0));
    check({tag, ".proto_err"}, W'(proto_err), W'(exp_perr));
  endtask

  // ---------------------------------------------------------------------------
  // Load: R rows, optional gap of gap_len idle cycles after row gap_after.
  // Entered and left at a negedge; on exit the current cycle is the start
  // cycle. Optional done pulses inside the gap are protocol errors.
  // ---------------------------------------------------------------------------
  logic [W-1:0] row_a [R];
  logic [W-1:0] row_b [R];

  task automatic load_phase(input bit pattern, input int gap_after, input int gap_len,
                            input logic [4:0] dm, input logic [4:0] dn, input logic [4:0] dk,
                            input bit noise);
    int next_row = 0;
    int gap_left = 0;
    int cur;
    int c0;
    int obs_start = -1;
    for (int i = 0; i < R; i++) begin
      row_a[i] = pattern ? rep(8'(i))  : rnd_word();
      row_b[i] = pattern ? rep(~8'(i)) : rnd_word();
    end
    c0 = cyc;
    do begin
      cur     = -1;
      gbuff_a = rnd_word();
      gbuff_b = rnd_word();
      m       = 5'($urandom);
      n       = 5'($urandom);
      k       = 5'($urandom);
      if (gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
        if (noise && $urandom_range(0, 1) == 1) begin
          done      = 1'b1;
          perr_pend = 1'b1;
        end
      end else begin
        cur      = next_row;
        in_valid = 1'b1;
        gbuff_a  = row_a[cur];
        gbuff_b  = row_b[cur];
        if (cur == 0) begin
          m = dm;
          n = dn;
          k = dk;
        end
        if (cur == gap_after) gap_left = gap_len;
        next_row++;
      end
      tick();
      in_valid = 1'b0;
      done     = 1'b0;
      if (cur >= 0) begin
        check("load.wr_en",     W'(wr_en),   W'(1));
        check("load.wr_addr",   W'(wr_addr), W'(cur));
        check("load.wr_data_a", wr_data_a,   row_a[cur]);
        check("load.wr_data_b", wr_data_b,   row_b[cur]);
      end else begin
        check("gap.wr_en", W'(wr_en), W'(0));
      end
      check("load.start",     W'(start),     W'(cur == R - 1));
      check("load.busy",      W'(busy),      W'(1));
      check("load.rd_en",     W'(rd_en),     W'(0));
      check("load.out_valid", W'(out_valid), W'(0));
      check("load.proto_err", W'(proto_err), W'(exp_perr));
      if (start && obs_start < 0) obs_start = cyc;
    end while (cur != R - 1);
    check("load.start_time", W'(obs_start - c0), W'(R + gap_len));
    check("load.m_o", W'(m_o), W'(dm));
    check("load.n_o", W'(n_o), W'(dn));
    check("load.k_o", W'(k_o), W'(dk));
  endtask

  // ---------------------------------------------------------------------------
  // Run: done arrives lat cycles after start. Optionally a stale done in the
  // start cycle and stray host rows while the core runs.
  // On exit done is driven in the current cycle.
  // ---------------------------------------------------------------------------
  task automatic run_phase(input int lat, input bit stale_done, input bit inject);
    done = stale_done;
    if (inject) begin
      in_valid  = 1'b1;
      gbuff_a   = rnd_word();
      perr_pend = 1'b1;
    end
    for (int i = 1; i <= lat; i++) begin
      tick();
      done     = 1'b0;
      in_valid = 1'b0;
      check("run.wr_en",     W'(wr_en),     W'(0));
      check("run.start",     W'(start),     W'(0));
      check("run.rd_en",     W'(rd_en),     W'(0));
      check("run.out_valid", W'(out_valid), W'(0));
      check("run.busy",      W'(busy),      W'(1));
      check("run.proto_err", W'(proto_err), W'(exp_perr));
      if (inject && i < lat && $urandom_range(0, 1) == 1) begin
        in_valid  = 1'b1;
        perr_pend = 1'b1;
      end
    end
    done = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Read: entered at the done cycle D. Checks cycles D+1..D+R+3. With
  // abort_row >= 0, rst is pulsed in the cycle that result row is shown.
  // ---------------------------------------------------------------------------
  task automatic read_phase(input bit inject, input int abort_row);
    int n_out = 0;
    for (int c = 1; c <= R + 3; c++) begin
      tick();
      done     = 1'b0;
      in_valid = 1'b0;
      check("read.rd_en", W'(rd_en), W'(c <= R));
      if (c <= R) check("read.rd_addr", W'(rd_addr), W'(c - 1));
      check("read.out_valid", W'(out_valid), W'(c >= 3 && c <= R + 2));
      if (c >= 3 && c <= R + 2) check("read.gbuff_out", gbuff_out, rep(8'(c - 3) ^ salt));
      else                      check("read.gbuff_out_zero", gbuff_out, W'(0));
      check("read.busy",      W'(busy),      W'(c <= R + 2));
      check("read.wr_en",     W'(wr_en),     W'(0));
      check("read.proto_err", W'(proto_err), W'(exp_perr));
      if (out_valid) n_out++;
      if (abort_row >= 0 && c == abort_row + 3) begin
        rst = 1'b1;
        #1;
        check("abort.out_valid", W'(out_valid), W'(0));
        check("abort.rd_en",     W'(rd_en),     W'(0));
        check("abort.busy",      W'(busy),      W'(0));
        check("abort.proto_err", W'(proto_err), W'(0));
        check("abort.m_o",       W'(m_o),       W'(0));
        exp_perr  = 1'b0;
        perr_pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
          tick();
          check_idle_outputs("post_abort");
          check("post_abort.busy", W'(busy), W'(0));
        end
        return;
      end
      if (inject && c <= R + 2 && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) in_valid = 1'b1;
        else                           done     = 1'b1;
        perr_pend = 1'b1;
      end
    end
    check("read.row_count", W'(n_out), W'(R));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    done     = 1'b0;
    gbuff_a  = '0;
    gbuff_b  = '0;
    m        = '0;
    n        = '0;
    k        = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset.busy", W'(busy), W'(0));
    check("reset.mnk",  W'({m_o, n_o, k_o}), W'(0));
    check("reset.wr_addr", W'(wr_addr), W'(0));
    rst = 1'b0;

    // Burst load straight out of reset, patterned rows, done 5 after start.
    load_phase(1'b1, -1, 0, 5'd16, 5'd16, 5'd16, 1'b0);
    run_phase(5, 1'b0, 1'b0);
    salt = 8'd0;
    read_phase(1'b0, -1);

    // Gapped load with a stale done on start and stray rows during RUN.
    load_phase(1'b0, 9, 3, 5'($urandom), 5'($urandom), 5'($urandom), 1'b0);
    run_phase($urandom_range(1, 8), 1'b1, 1'b1);
    check("inject.proto_err_set", W'(proto_err), W'(1));
    salt = 8'($urandom);
    read_phase(1'b0, -1);

    // Back-to-back load the cycle after out_valid falls.
    load_phase(1'b0, -1, 0, 5'($urandom), 5'($urandom), 5'($urandom), 1'b0);
    run_phase($urandom_range(1, 6), 1'b0, 1'b0);
    salt = 8'($urandom);
    read_phase(1'b1, -1);

    // done in IDLE: ignored, error flag stays set.
    done      = 1'b1;
    perr_pend = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      done = 1'b0;
      check_idle_outputs("idle_done");
      check("idle_done.busy", W'(busy), W'(0));
    end

    // Reset in the middle of the readout, then a fresh full transfer.
    load_phase(1'b0, -1, 0, 5'($urandom), 5'($urandom), 5'($urandom), 1'b0);
    run_phase(3, 1'b0, 1'b0);
    salt = 8'($urandom);
    read_phase(1'b0, 12);
    load_phase(1'b1, -1, 0, 5'd7, 5'd9, 5'd11, 1'b0);
    run_phase(2, 1'b0, 1'b0);
    salt = 8'd0;
    read_phase(1'b0, -1);

    // Randomised transfers.
    for (int t = 0; t < 3; t++) begin
      load_phase(1'b0, $urandom_range(0, R - 2), $urandom_range(0, 4),
                 5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
      run_phase($urandom_range(1, 10), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      salt = 8'($urandom);
      read_phase(1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
